// File: rtl/freq_scan_ctrl.sv
// freq_scan_ctrl: shares one frequency counter across NUM_CHANNELS muxed input clocks,
// sequencing settle / warm-up discard / capture per channel into a readable result file.
//
// state   | meaning
// IDLE    | counter held in reset, waiting for enable (sweep restarts at channel 0)
// SELECT  | mux switched to current channel, counter held in reset while input settles
// MEASURE | counter running; warm-up results discarded, then one result captured
// STORE   | one-cycle update pulse, channel index advances

module freq_scan_ctrl #(
  parameter int     NUM_CHANNELS   = 4,
  parameter int     SETTLE_CYCLES  = 16,
  parameter int     DISCARD_COUNT  = 1,
  parameter longint TIMEOUT_CYCLES = 600000000,
  localparam int    CHW            = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  output logic [CHW-1:0]  fc_select,
  output logic            fc_resetn,
  input  logic [31:0]     fc_frequency,
  input  logic            fc_valid,
  input  logic [CHW-1:0]  rd_channel,
  output logic [31:0]     rd_frequency,
  output logic            rd_timeout,
  output logic            upd_valid,
  output logic [CHW-1:0]  upd_channel,
  output logic [31:0]     upd_frequency,
  output logic            timeout_err,
  output logic            scan_done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_STORE   = 2'd3;

  localparam logic [CHW-1:0] LAST_CH     = CHW'(NUM_CHANNELS - 1);
  localparam logic [CHW:0]   NUM_CH      = (CHW+1)'(NUM_CHANNELS);
  localparam logic [31:0]    SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [3:0]     DISC_INIT   = 4'(DISCARD_COUNT);
  localparam logic [31:0]    TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]     r_state;
  logic [CHW-1:0] r_ch_idx;
  logic [CHW-1:0] r_fc_select;
  logic           r_fc_resetn;
  logic [31:0]    r_settle_cnt;
  logic [3:0]     r_disc_cnt;
  logic [31:0]    r_tmo_cnt;
  logic           r_tmo_hit;
  logic [31:0]    r_res_freq [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_res_tmo;
  logic [31:0]    r_rd_frequency;
  logic           r_rd_timeout;
  logic           r_upd_valid;
  logic [CHW-1:0] r_upd_channel;
  logic [31:0]    r_upd_frequency;
  logic           r_timeout_err;
  logic           r_scan_done;

  logic           w_in_measure;
  logic           w_capture;
  logic           w_timeout;
  logic           w_commit;
  logic [31:0]    w_commit_freq;
  logic [CHW-1:0] w_ch_next;
  logic           w_rd_in_range;

  // A dropped enable aborts the measurement before any capture or timeout can commit.
  assign w_in_measure  = (r_state == ST_MEASURE) && enable;
  assign w_capture     = w_in_measure && fc_valid && (r_disc_cnt == 4'd0);
  assign w_timeout     = w_in_measure && r_tmo_hit && !w_capture;
  assign w_commit      = w_capture || w_timeout;
  assign w_commit_freq = w_capture ? fc_frequency : 32'd0;
  assign w_ch_next     = (r_ch_idx == LAST_CH) ? '0 : r_ch_idx + 1'b1;
  assign w_rd_in_range = ({1'b0, rd_channel} < NUM_CH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= ST_IDLE;
      r_ch_idx        <= '0;
      r_fc_select     <= '0;
      r_fc_resetn     <= 1'b0;
      r_settle_cnt    <= '0;
      r_disc_cnt      <= '0;
      r_tmo_cnt       <= '0;
      r_tmo_hit       <= 1'b0;
      r_res_tmo       <= '0;
      r_rd_frequency  <= '0;
      r_rd_timeout    <= 1'b0;
      r_upd_valid     <= 1'b0;
      r_upd_channel   <= '0;
      r_upd_frequency <= '0;
      r_timeout_err   <= 1'b0;
      r_scan_done     <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) r_res_freq[i] <= '0;
    end else begin
      r_upd_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_scan_done   <= 1'b0;
      r_rd_frequency <= w_rd_in_range ? r_res_freq[rd_channel] : 32'd0;
      r_rd_timeout   <= w_rd_in_range ? r_res_tmo[rd_channel]  : 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_fc_resetn <= 1'b0;
          if (enable) begin
            r_state      <= ST_SELECT;
            r_ch_idx     <= '0;
            r_fc_select  <= '0;
            r_settle_cnt <= SETTLE_LAST;
          end
        end
        ST_SELECT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (r_settle_cnt == 32'd0) begin
            r_state     <= ST_MEASURE;
            r_fc_resetn <= 1'b1;
            r_disc_cnt  <= DISC_INIT;
            r_tmo_cnt   <= '0;
            r_tmo_hit   <= 1'b0;
          end else begin
            r_settle_cnt <= r_settle_cnt - 32'd1;
          end
        end
        ST_MEASURE: begin
          r_tmo_cnt <= r_tmo_cnt + 32'd1;
          // Terminal compare is registered so the 32-bit equality stays off the commit path.
          r_tmo_hit <= (r_tmo_cnt == TMO_LAST);
          if (!enable) begin
            r_state     <= ST_IDLE;
            r_fc_resetn <= 1'b0;
          end else if (w_commit) begin
            r_state               <= ST_STORE;
            r_fc_resetn           <= 1'b0;
            r_res_freq[r_ch_idx]  <= w_commit_freq;
            r_res_tmo[r_ch_idx]   <= w_timeout;
            r_upd_valid           <= 1'b1;
            r_upd_channel         <= r_ch_idx;
            r_upd_frequency       <= w_commit_freq;
            r_timeout_err         <= w_timeout;
            r_scan_done           <= (r_ch_idx == LAST_CH);
          end else if (fc_valid) begin
            r_disc_cnt <= r_disc_cnt - 4'd1;
          end
        end
        default: begin
          r_ch_idx    <= w_ch_next;
          r_fc_resetn <= 1'b0;
          if (enable) begin
            r_state      <= ST_SELECT;
            r_fc_select  <= w_ch_next;
            r_settle_cnt <= SETTLE_LAST;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign fc_select     = r_fc_select;
  assign fc_resetn     = r_fc_resetn;
  assign rd_frequency  = r_rd_frequency;
  assign rd_timeout    = r_rd_timeout;
  assign upd_valid     = r_upd_valid;
  assign upd_channel   = r_upd_channel;
  assign upd_frequency = r_upd_frequency;
  assign timeout_err   = r_timeout_err;
  assign scan_done     = r_scan_done;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Scoreboard bench for freq_scan_ctrl: directed sweeps with a counter stub returning
// 1000*(sel+1); expected updates are queued by the stimulus and popped by a monitor.
module tb_freq_scan_ctrl;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [1:0]  fc_select;
  logic        fc_resetn;
  logic [31:0] fc_frequency;
  logic        fc_valid;
  logic [1:0]  rd_channel;
  logic [31:0] rd_frequency;
  logic        rd_timeout;
  logic        upd_valid;
  logic [1:0]  upd_channel;
  logic [31:0] upd_frequency;
  logic        timeout_err;
  logic        scan_done;

  freq_scan_ctrl #(
    .NUM_CHANNELS(4), .SETTLE_CYCLES(4), .DISCARD_COUNT(1), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fc_select(fc_select), .fc_resetn(fc_resetn),
    .fc_frequency(fc_frequency), .fc_valid(fc_valid),
    .rd_channel(rd_channel), .rd_frequency(rd_frequency), .rd_timeout(rd_timeout),
    .upd_valid(upd_valid), .upd_channel(upd_channel), .upd_frequency(upd_frequency),
    .timeout_err(timeout_err), .scan_done(scan_done)
  );

  typedef struct {
    int          ch;
    logic [31:0] freq;
    logic        tmo;
    logic        scan;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   entry_cyc = 0;
  bit   chk_resetn = 0;
  logic [3:0] silent_mask = 4'b0000;
  int   special_ch = -1;
  int   bias = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input logic [31:0] f, input logic t, input logic s);
    exp_t e;
    e.ch = ch; e.freq = f; e.tmo = t; e.scan = s;
    sb_q.push_back(e);
  endtask

  task automatic wait_upd(input int ch, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (upd_valid && (upd_channel == 2'(ch))) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_upd_ch%0d: no update within %0d cycles", ch, budget);
    end
  endtask

  task automatic wait_meas(input int ch, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fc_resetn && (fc_select == 2'(ch))) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_meas_ch%0d: no measure within %0d cycles", ch, budget);
    end
  endtask

  task automatic rd_check(input int ch, input logic [31:0] f, input logic t);
    rd_channel = 2'(ch);
    @(negedge clk);
    chk($sformatf("rd_freq_ch%0d", ch), rd_frequency, f);
    chk($sformatf("rd_tmo_ch%0d", ch), 32'(rd_timeout), 32'(t));
  endtask

  // Counter stub: pulses 10 cycles after fc_resetn rises, then every 50.
  initial begin
    int k;
    k = -1;
    fc_valid = 1'b0;
    fc_frequency = '0;
    forever begin
      @(negedge clk);
      if (fc_resetn) k++; else k = -1;
      fc_valid = 1'b0;
      if (fc_resetn && !silent_mask[fc_select]) begin
        if (int'(fc_select) == special_ch) fc_valid = (k == 10) || (k == 199);
        else fc_valid = (k >= 10) && (((k - 10) % 50) == 0);
      end
      fc_frequency = 32'(1000 * (int'(fc_select) + 1) + bias);
    end
  end

  // Scoreboard monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resetn) begin
      if (upd_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL upd_unexpected: got ch%0d freq %0d expected none", upd_channel, upd_frequency);
        end else begin
          e = sb_q.pop_front();
          chk("upd_channel", 32'(upd_channel), 32'(e.ch));
          chk("upd_frequency", upd_frequency, e.freq);
          chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
          chk("scan_done", 32'(scan_done), 32'(e.scan));
        end
      end else if (timeout_err || scan_done) begin
        checks++; failures++;
        $display("FAIL stray_pulse: got tmo=%0d scan=%0d expected 0 without upd_valid", timeout_err, scan_done);
      end
    end
  end

  // MEASURE entry tracking and settle-window length after each mux change.
  initial begin
    logic       prev_fcr;
    logic [1:0] prev_sel;
    bit         armed;
    int         lowcnt;
    prev_fcr = 1'b0; prev_sel = 2'd0; armed = 0; lowcnt = 0;
    forever begin
      @(negedge clk);
      if (fc_resetn && !prev_fcr) entry_cyc = cyc;
      if (chk_resetn && (fc_select != prev_sel)) begin armed = 1; lowcnt = 0; end
      if (armed) begin
        if (!fc_resetn) lowcnt++;
        else begin
          chk($sformatf("settle_low_ch%0d", fc_select), 32'(lowcnt), 32'd4);
          armed = 0;
        end
      end
      prev_fcr = fc_resetn;
      prev_sel = fc_select;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; rd_channel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_fc_select", 32'(fc_select), 32'd0);
    chk("rst_fc_resetn", 32'(fc_resetn), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_rd_frequency", rd_frequency, 32'd0);
    chk("rst_rd_timeout", 32'(rd_timeout), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_waits_fc_resetn", 32'(fc_resetn), 32'd0);

    // Basic sweep with read-during-write on ch3.
    push_exp(0, 1000, 0, 0); push_exp(1, 2000, 0, 0);
    push_exp(2, 3000, 0, 0); push_exp(3, 4000, 0, 1);
    rd_channel = 2'd3; chk_resetn = 1; enable = 1'b1;
    wait_upd(3, 1500);
    chk("rdw_old", rd_frequency, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    chk("rdw_new", rd_frequency, 32'd4000);
    chk_resetn = 0;
    rd_check(0, 1000, 0); rd_check(1, 2000, 0); rd_check(2, 3000, 0);

    // Timeout on silent ch2.
    silent_mask = 4'b0100;
    push_exp(0, 1000, 0, 0); push_exp(1, 2000, 0, 0);
    push_exp(2, 0, 1, 0); push_exp(3, 4000, 0, 1);
    enable = 1'b1;
    wait_upd(2, 1500);
    chk("timeout_latency", 32'(cyc - entry_cyc), 32'd201);
    wait_upd(3, 1500);
    enable = 1'b0;
    silent_mask = 4'b0000;
    rd_check(2, 0, 1);

    // Capture on the cycle the timeout counter reaches 199 on ch1.
    special_ch = 1;
    push_exp(0, 1000, 0, 0); push_exp(1, 2000, 0, 0);
    push_exp(2, 3000, 0, 0); push_exp(3, 4000, 0, 1);
    enable = 1'b1;
    wait_upd(1, 1500);
    chk("late_capture_latency", 32'(cyc - entry_cyc), 32'd200);
    wait_upd(3, 1500);
    enable = 1'b0;
    special_ch = -1;
    rd_check(2, 3000, 0); rd_check(1, 2000, 0);

    // Abort mid-MEASURE on ch1, then re-enable from ch0.
    bias = 7;
    push_exp(0, 1007, 0, 0);
    enable = 1'b1;
    wait_upd(0, 500);
    wait_meas(1, 200);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_fc_resetn", 32'(fc_resetn), 32'd0);
    repeat (80) @(negedge clk);
    rd_check(1, 2000, 0); rd_check(0, 1007, 0);
    bias = 0;
    push_exp(0, 1000, 0, 0);
    enable = 1'b1;
    wait_upd(0, 500);

    // Asynchronous reset during ch1 MEASURE.
    wait_meas(1, 200);
    repeat (5) @(negedge clk);
    rd_channel = 2'd0;
    resetn = 1'b0;
    #1;
    chk("async_fc_resetn", 32'(fc_resetn), 32'd0);
    chk("async_fc_select", 32'(fc_select), 32'd0);
    chk("async_upd_valid", 32'(upd_valid), 32'd0);
    chk("async_rd_frequency", rd_frequency, 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rd_check(0, 0, 0); rd_check(1, 0, 0); rd_check(2, 0, 0); rd_check(3, 0, 0);
    push_exp(0, 1000, 0, 0);
    enable = 1'b1;
    wait_upd(0, 500);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_scan_ctrl.md
# freq_scan_ctrl

- Time-multiplexes one frequency-counter instance across NUM_CHANNELS input clocks.
- Sequences the counter for each channel: select mux input, hold counter in reset to settle, discard warm-up results, capture one result.
- Stores per-channel results in a register file with a read port, and reports each update and each completed sweep.
- Sits between the clock-input mux feeding the counter's `inp_clock` and the register/status logic that exposes clock frequencies.

## Interface
- `NUM_CHANNELS`, 4: number of muxed input clocks, 2..16.
- `SETTLE_CYCLES`, 16: clk cycles counter reset is held after a mux change, ≥1.
- `DISCARD_COUNT`, 1: counter valid pulses ignored per channel before capture, 0..15.
- `TIMEOUT_CYCLES`, 600000000: clk cycles allowed in MEASURE before forced capture. Must be < 2^32.
- CHW = max(1, clog2(NUM_CHANNELS)).
- `clk` in 1: single clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 = scan continuously, 0 = stop.
- `fc_select` out CHW: input-clock mux select.
- `fc_resetn` out 1: drives the counter's active-low reset.
- `fc_frequency` in 32: counter result.
- `fc_valid` in 1: counter result strobe, single-cycle pulse.
- `rd_channel` in CHW: result read address.
- `rd_frequency` out 32: stored result for `rd_channel`.
- `rd_timeout` out 1: stored timeout flag for `rd_channel`.
- `upd_valid` out 1: one-cycle pulse when a channel result is written.
- `upd_channel` out CHW: channel written, valid with `upd_valid`.
- `upd_frequency` out 32: value written, valid with `upd_valid`.
- `timeout_err` out 1: one-cycle pulse coinciding with `upd_valid` for a timed-out channel.
- `scan_done` out 1: one-cycle pulse coinciding with `upd_valid` for channel NUM_CHANNELS-1.

## Operation
Reset values:
- State = IDLE, channel index = 0, all counters = 0.
- `fc_select` = 0, `fc_resetn` = 0.
- All `upd_*`, `timeout_err`, `scan_done` = 0.
- Result file frequencies = 0, timeout flags = 0, `rd_*` = 0.

States:
- **IDLE**
  - `fc_resetn` = 0; `fc_select` holds its last value.
  - `enable` = 1 → SELECT with channel index = 0; the sweep always restarts at 0.
- **SELECT**
  - `fc_select` = channel index, `fc_resetn` = 0.
  - Settle counter is loaded with SETTLE_CYCLES-1 on entry and decrements each cycle.
  - At 0 → MEASURE; discard counter loads DISCARD_COUNT, timeout counter clears.
- **MEASURE**
  - `fc_resetn` = 1; timeout counter increments every cycle.
  - `fc_valid` with discard counter > 0 → decrement, stay.
  - `fc_valid` with discard counter = 0 → latch `fc_frequency`, timeout flag = 0 → STORE.
  - Timeout counter reaches TIMEOUT_CYCLES-1 without capture → latched value = 0, timeout flag = 1 → STORE.
  - If `fc_valid` arrives on that same cycle, the valid capture wins: the real value is stored, no timeout.
- **STORE** (exactly one cycle)
  - `fc_resetn` = 0.
  - Writes the result file entry for the channel index.
  - Pulses `upd_valid`/`upd_channel`/`upd_frequency`, `timeout_err` if the flag is set, and `scan_done` if index = NUM_CHANNELS-1.
  - Index advances, wrapping NUM_CHANNELS-1 → 0.
  - Next state: `enable` = 1 → SELECT, else IDLE.

Abort and idle behaviour:
- `enable` = 0 while in SELECT or MEASURE → IDLE next cycle, `fc_resetn` = 0.
- An aborted measurement writes nothing and pulses nothing.
- `fc_valid` outside MEASURE is ignored.

Read port and storage:
- `rd_frequency`/`rd_timeout` are registered: they reflect the `rd_channel` sampled on the previous edge.
- A read of an entry being written in STORE returns the old value that cycle and the new value from the next cycle.
- `rd_channel` ≥ NUM_CHANNELS returns 0/0.
- Result values are stored unmodified (32 bits, no arithmetic).

## Timing
- `fc_select` changes on the clk edge entering SELECT.
- `fc_resetn` is low for exactly SETTLE_CYCLES cycles after that change, plus the STORE cycle before it.
- `fc_resetn` rises on the edge entering MEASURE.
- `fc_valid` sampled at edge N → `upd_valid` high during cycle N+1 (STORE) → SELECT of the next channel at N+2.
- Per-channel latency with no discards and an immediate `fc_valid`: SETTLE_CYCLES + 2 cycles from SELECT entry to the next SELECT entry.
- Timeout: `upd_valid` is asserted TIMEOUT_CYCLES+1 cycles after MEASURE entry.
- Pulses `upd_valid`, `timeout_err`, `scan_done` never exceed one cycle.
- Reset assertion mid-operation forces all reset values immediately and asynchronously. The first SELECT after release waits for `enable`.

## Test plan
Common parameters: NUM_CHANNELS=4, SETTLE_CYCLES=4, DISCARD_COUNT=1, TIMEOUT_CYCLES=200. Counter modelled by a stub that returns 1000*(sel+1).
- **Basic sweep:** `enable`=1; stub pulses `fc_valid` 10 cycles after `fc_resetn` rises, repeating every 50 cycles. → Second pulse captured; upd sequence is ch0=1000, ch1=2000, ch2=3000, ch3=4000; `scan_done` with ch3; `fc_resetn` low for exactly 4 cycles after each `fc_select` change.
- **Timeout:** stub silent on ch2. → `upd_valid` ch2 with frequency 0 and `timeout_err` at MEASURE entry + 201 cycles; `rd_channel`=2 gives `rd_timeout`=1. A later successful sweep clears the flag.
- **Simultaneous valid and timeout:** on ch1, the capture-eligible `fc_valid` arrives on the cycle the timeout counter reaches 199. → Stores 2000; no `timeout_err`.
- **Abort:** `enable` drops mid-MEASURE on ch1. → IDLE next cycle; `fc_resetn`=0; no `upd_valid`; the ch1 entry is unchanged. Re-enable restarts at ch0.
- **Read-during-write:** `rd_channel`=3 held through the ch3 STORE. → Old value in the STORE cycle, 4000 on the following cycle.
- **Reset mid-measure:** `resetn` low in MEASURE. → All outputs and results 0 immediately; no pulses; after release with `enable`=1 the sweep restarts at ch0.
